// File: rtl/mtm_alu_ctrl.sv
// mtm_alu_ctrl: sequencer between the request deserializer, the ALU and the
// response serializer. Accepts one request at a time and validates it. Legal
// requests are launched on the ALU with a completion timeout. The 3-bit result
// CRC is computed serially, and a data or error response is presented to the
// serializer.
// Optional build macro: MTM_ALU_CTRL_STATS_EN adds saturating response
// counters stat_ok / stat_err.
module mtm_alu_ctrl #(
  parameter int ALU_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [2:0]  in_op,
  input  logic [5:0]  in_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [31:0] alu_c,
  input  logic [3:0]  alu_flags,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_err,
  output logic [31:0] tx_c,
  output logic [7:0]  tx_ctl
`ifdef MTM_ALU_CTRL_STATS_EN
  ,
  output logic [15:0] stat_ok,
  output logic [15:0] stat_err
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, CRC = 2'd2, SEND = 2'd3} state_t;

  localparam logic [7:0] TMO_LAST = 8'(ALU_TIMEOUT - 1);
  localparam logic [5:0] BIT_LAST = 6'd36;
  localparam logic [5:0] ERR_OP   = 6'b001001;

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  tmo_cnt;
  logic [5:0]  bit_cnt;
  logic [31:0] c_p1;
  logic [3:0]  flags_p1;
  logic [2:0]  crc_p1;
  logic [2:0]  crc_next;
  logic [36:0] msg;
  logic        msg_bit;
  logic        op_legal;
  logic        req_err;
  logic        accept;
  logic        exec_done;
  logic        exec_tmo;
  logic        crc_last;
  logic        handshake;

  // One CRC step for polynomial x^3+x+1, message bit entering MSB first.
  function automatic logic [2:0] crc_step(input logic [2:0] crc, input logic b);
    logic fb;
    fb = crc[2] ^ b;
    return {crc[1], crc[0] ^ fb, fb};
  endfunction

  // Error control byte: marker bit, flags, and a parity bit that makes the byte even.
  function automatic logic [7:0] err_ctl(input logic [5:0] flags);
    return {1'b1, flags, ^{1'b1, flags}};
  endfunction

  assign op_legal = (in_op == 3'b000) || (in_op == 3'b001) ||
                    (in_op == 3'b100) || (in_op == 3'b101);
  assign req_err  = (in_err != 6'd0) || !op_legal;

  // CRC message is the result word, a zero spacer and the flags, walked MSB first.
  assign msg      = {c_p1, 1'b0, flags_p1};
  assign msg_bit  = msg[BIT_LAST - bit_cnt];
  assign crc_next = crc_step(crc_p1, msg_bit);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state selection and the per-state events that drive the registered outputs.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    exec_done = 1'b0;
    exec_tmo  = 1'b0;
    crc_last  = 1'b0;
    handshake = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept  = 1'b1;
          state_d = req_err ? SEND : EXEC;
        end
      end
      EXEC: begin
        // A completion in the timeout cycle still counts as a completion.
        if (alu_done) begin
          exec_done = 1'b1;
          state_d   = CRC;
        end else if (tmo_cnt == TMO_LAST) begin
          exec_tmo = 1'b1;
          state_d  = SEND;
        end
      end
      CRC: begin
        if (bit_cnt == BIT_LAST) begin
          crc_last = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (tx_valid && tx_ready) begin
          handshake = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs and control counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      alu_start <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= 3'b000;
      tx_valid  <= 1'b0;
      tx_err    <= 1'b0;
      tx_c      <= '0;
      tx_ctl    <= 8'h00;
      tmo_cnt   <= '0;
      bit_cnt   <= '0;
    end else begin
      alu_start <= 1'b0;
      if (accept) begin
        in_ready <= 1'b0;
        if (req_err) begin
          tx_valid <= 1'b1;
          tx_err   <= 1'b1;
          tx_c     <= '0;
          tx_ctl   <= err_ctl((in_err != 6'd0) ? in_err : ERR_OP);
        end else begin
          alu_a     <= in_a;
          alu_b     <= in_b;
          alu_op    <= in_op;
          alu_start <= 1'b1;
          tmo_cnt   <= '0;
        end
      end
      if (state_q == EXEC && !exec_done && !exec_tmo) tmo_cnt <= tmo_cnt + 8'd1;
      if (exec_tmo) begin
        tx_valid <= 1'b1;
        tx_err   <= 1'b1;
        tx_c     <= '0;
        tx_ctl   <= err_ctl(ERR_OP);
      end
      if (exec_done) bit_cnt <= '0;
      if (state_q == CRC) bit_cnt <= crc_last ? 6'd0 : bit_cnt + 6'd1;
      if (crc_last) begin
        tx_valid <= 1'b1;
        tx_err   <= 1'b0;
        tx_c     <= c_p1;
        tx_ctl   <= {1'b0, flags_p1, crc_next};
      end
      if (handshake) begin
        tx_valid <= 1'b0;
        in_ready <= 1'b1;
      end
    end
  end

  // ---- stage p1: ALU result capture and serial CRC accumulation ----
  always_ff @(posedge clk) begin
    if (exec_done) begin
      c_p1     <= alu_c;
      flags_p1 <= alu_flags;
      crc_p1   <= 3'b000;
    end else if (state_q == CRC) begin
      crc_p1 <= crc_next;
    end
  end

`ifdef MTM_ALU_CTRL_STATS_EN
  // Saturating 16-bit increment.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Count accepted data and error responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ok  <= '0;
      stat_err <= '0;
    end else if (handshake) begin
      if (tx_err) stat_err <= sat_inc(stat_err);
      else        stat_ok  <= sat_inc(stat_ok);
    end
  end
`endif

endmodule

// File: tb/tb_mtm_alu_ctrl.sv
// Directed testbench for mtm_alu_ctrl (ALU_TIMEOUT = 15); the bench plays the ALU.
module tb_mtm_alu_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_op;
  logic [5:0]  in_err;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done;
  logic [31:0] alu_c;
  logic [3:0]  alu_flags;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_err;
  logic [31:0] tx_c;
  logic [7:0]  tx_ctl;
`ifdef MTM_ALU_CTRL_STATS_EN
  logic [15:0] stat_ok;
  logic [15:0] stat_err;
`endif

  int checks;
  int failures;
  int start_cnt;
  int n;

  mtm_alu_ctrl #(.ALU_TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_err    (in_err),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_start (alu_start),
    .alu_done  (alu_done),
    .alu_c     (alu_c),
    .alu_flags (alu_flags),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_err    (tx_err),
    .tx_c      (tx_c),
    .tx_ctl    (tx_ctl)
`ifdef MTM_ALU_CTRL_STATS_EN
    ,
    .stat_ok   (stat_ok),
    .stat_err  (stat_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count launch pulses, sampled on the inactive edge.
  always @(negedge clk) if (alu_start === 1'b1) start_cnt = start_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance until tx_valid rises or the budget runs out; cnt = cycles waited.
  task automatic wait_tx(input int limit, output int cnt);
    cnt = 0;
    while (tx_valid !== 1'b1 && cnt < limit) begin
      tick(1);
      cnt = cnt + 1;
    end
  endtask

  initial begin
    checks = 0; failures = 0; start_cnt = 0; n = 0;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_err = '0;
    alu_done = 1'b0; alu_c = '0; alu_flags = '0; tx_ready = 1'b0;
    tick(2);

    // Reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_alu_start", alu_start, 0);
    check("rst_tx_err", tx_err, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_tx_c", tx_c, 0);
    check("rst_tx_ctl", tx_ctl, 8'h00);
`ifdef MTM_ALU_CTRL_STATS_EN
    check("rst_stat_ok", stat_ok, 0);
    check("rst_stat_err", stat_err, 0);
`endif
    rst = 1'b0;
    tick(1);

    // ADD 0+0, ALU answers C=0 flags=0010 -> ctl 0x16
    in_a = 32'd0; in_b = 32'd0; in_op = 3'b100; in_err = 6'd0; in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    check("add_start", alu_start, 1);
    check("add_in_ready", in_ready, 0);
    check("add_alu_op", alu_op, 3'b100);
    tick(1);
    check("add_start_pulse", alu_start, 0);
    tick(1);
    alu_c = 32'd0; alu_flags = 4'b0010; alu_done = 1'b1;
    tick(1);
    alu_done = 1'b0;
    wait_tx(60, n);
    check("add_latency", n, 37);
    check("add_tx_err", tx_err, 0);
    check("add_tx_c", tx_c, 32'd0);
    check("add_tx_ctl", tx_ctl, 8'h16);
    check("add_start_count", start_cnt, 1);
    tx_ready = 1'b1;
    tick(1);
    tx_ready = 1'b0;
    check("add_hs_valid", tx_valid, 0);
    check("add_hs_ready", in_ready, 1);
`ifdef MTM_ALU_CTRL_STATS_EN
    check("add_stat_ok", stat_ok, 1);
`endif

    // SUB with done in the launch cycle, C=1 flags=1010 -> ctl 0x51, backpressure 10 cycles
    in_a = 32'hDEADBEEF; in_b = 32'h12345678; in_op = 3'b101; in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    check("sub_alu_a", alu_a, 32'hDEADBEEF);
    check("sub_alu_b", alu_b, 32'h12345678);
    check("sub_alu_op", alu_op, 3'b101);
    alu_c = 32'd1; alu_flags = 4'b1010; alu_done = 1'b1;
    tick(1);
    alu_done = 1'b0;
    wait_tx(60, n);
    check("sub_latency", n, 37);
    check("sub_tx_c", tx_c, 32'd1);
    check("sub_tx_ctl", tx_ctl, 8'h51);
    in_valid = 1'b1; in_op = 3'b000; in_err = 6'h3F;
    for (int i = 0; i < 10; i++) begin
      check("bp_tx_valid", tx_valid, 1);
      check("bp_tx_err", tx_err, 0);
      check("bp_tx_c", tx_c, 32'd1);
      check("bp_tx_ctl", tx_ctl, 8'h51);
      check("bp_in_ready", in_ready, 0);
      tick(1);
    end
    in_valid = 1'b0; in_err = 6'd0;
    check("bp_start_count", start_cnt, 2);
    tx_ready = 1'b1;
    tick(1);
    tx_ready = 1'b0;
    check("bp_hs_valid", tx_valid, 0);
    check("bp_hs_ready", in_ready, 1);

    // Deserializer error frame -> immediate error response 0xC9
    in_op = 3'b100; in_err = 6'b100100; in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0; in_err = 6'd0;
    check("ferr_tx_valid", tx_valid, 1);
    check("ferr_tx_err", tx_err, 1);
    check("ferr_tx_c", tx_c, 32'd0);
    check("ferr_tx_ctl", tx_ctl, 8'hC9);
    check("ferr_no_start", start_cnt, 2);
    tx_ready = 1'b1;
    tick(1);
    tx_ready = 1'b0;
    check("ferr_hs_ready", in_ready, 1);
`ifdef MTM_ALU_CTRL_STATS_EN
    check("ferr_stat_err", stat_err, 1);
`endif

    // Illegal opcode -> error response 0x93
    in_op = 3'b011; in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    check("ill_tx_valid", tx_valid, 1);
    check("ill_tx_err", tx_err, 1);
    check("ill_tx_ctl", tx_ctl, 8'h93);
    check("ill_no_start", start_cnt, 2);
    tx_ready = 1'b1;
    tick(1);
    tx_ready = 1'b0;

    // ALU never answers -> timeout response 15 cycles after launch; late done ignored
    in_a = 32'd5; in_b = 32'd3; in_op = 3'b000; in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    check("tmo_start", alu_start, 1);
    wait_tx(40, n);
    check("tmo_latency", n, 15);
    check("tmo_tx_err", tx_err, 1);
    check("tmo_tx_c", tx_c, 32'd0);
    check("tmo_tx_ctl", tx_ctl, 8'h93);
    alu_c = 32'hFFFF0000; alu_flags = 4'b1111; alu_done = 1'b1;
    tick(1);
    alu_done = 1'b0;
    check("tmo_late_valid", tx_valid, 1);
    check("tmo_late_ctl", tx_ctl, 8'h93);
    tx_ready = 1'b1;
    tick(1);
    tx_ready = 1'b0;
    alu_done = 1'b1;
    tick(1);
    alu_done = 1'b0;
    tick(2);
    check("idle_done_valid", tx_valid, 0);
    check("idle_done_ready", in_ready, 1);
    check("idle_done_start", start_cnt, 3);

    // Reset asserted during CRC -> reset values, no response, then normal operation
    in_a = 32'd7; in_b = 32'd9; in_op = 3'b100; in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    alu_c = 32'hFFFFFFFF; alu_flags = 4'b1111; alu_done = 1'b1;
    tick(1);
    alu_done = 1'b0;
    tick(10);
    rst = 1'b1;
    #2;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_tx_valid", tx_valid, 0);
    check("mid_rst_alu_a", alu_a, 0);
    check("mid_rst_alu_b", alu_b, 0);
    check("mid_rst_alu_op", alu_op, 0);
    check("mid_rst_tx_ctl", tx_ctl, 8'h00);
`ifdef MTM_ALU_CTRL_STATS_EN
    check("mid_rst_stat_ok", stat_ok, 0);
    check("mid_rst_stat_err", stat_err, 0);
`endif
    tick(1);
    rst = 1'b0;
    tick(45);
    check("mid_rst_no_resp", tx_valid, 0);
    check("mid_rst_idle", in_ready, 1);
    in_a = 32'd1; in_b = 32'd0; in_op = 3'b001; in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    check("post_rst_start", alu_start, 1);
    check("post_rst_op", alu_op, 3'b001);
    tick(2);
    alu_c = 32'd1; alu_flags = 4'b1010; alu_done = 1'b1;
    tick(1);
    alu_done = 1'b0;
    wait_tx(60, n);
    check("post_rst_latency", n, 37);
    check("post_rst_tx_c", tx_c, 32'd1);
    check("post_rst_tx_ctl", tx_ctl, 8'h51);
    tx_ready = 1'b1;
    tick(1);
    tx_ready = 1'b0;
    check("post_rst_hs_ready", in_ready, 1);
`ifdef MTM_ALU_CTRL_STATS_EN
    check("post_rst_stat_ok", stat_ok, 1);
    check("post_rst_stat_err", stat_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mtm_alu_ctrl.md
Name: mtm_alu_ctrl

Overview:
Core sequencer between the input deserializer, the ALU datapath and the output serializer.
- Accepts one decoded request frame (A, B, OP, error flags) per handshake.
- Validates the opcode, launches the ALU and waits for completion with a timeout.
- Computes the 3-bit result CRC serially and hands a data or error response to the serializer.
- Exactly one request is in flight at a time; backpressure comes from the serializer.

Parameters:
ALU_TIMEOUT, 15, max cycles from alu_start to alu_done before an ERR_OP response is forced (1..255)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  request frame available
in_ready  out  1  controller can accept a request
in_a  in  32  operand A
in_b  in  32  operand B
in_op  in  3  opcode
in_err  in  6  deserializer error flags; nonzero means error frame
alu_a  out  32  registered operand A to ALU
alu_b  out  32  registered operand B to ALU
alu_op  out  3  registered opcode to ALU
alu_start  out  1  one-cycle launch pulse
alu_done  in  1  ALU result valid (single-cycle pulse)
alu_c  in  32  ALU result
alu_flags  in  4  {carry, overflow, zero, negative}
tx_valid  out  1  response available
tx_ready  in  1  serializer accepts response
tx_err  out  1  1 = error response, 0 = data response
tx_c  out  32  result word (0 for error response)
tx_ctl  out  8  response control byte

Behaviour:
Reset values:
- in_ready=1; tx_valid=0, alu_start=0, tx_err=0.
- alu_a, alu_b, tx_c=0; alu_op=3'b000; tx_ctl=8'h00.
- state=IDLE.
- All outputs are registered.

Legal opcodes: AND=000, OR=001, ADD=100, SUB=101.

FSM states: IDLE, EXEC, CRC, SEND.
- IDLE: in_ready=1. Accept on in_valid&in_ready; in_ready drops the next cycle.
  - in_err!=0: load err_flags=in_err, go to SEND with tx_err=1.
  - else illegal in_op: load err_flags=6'b001001, go to SEND with tx_err=1.
  - else: latch alu_a/alu_b/alu_op, pulse alu_start for exactly one cycle (the cycle after accept), go to EXEC.
- EXEC: timeout counter starts at 0 and increments each cycle.
  - alu_done: latch alu_c and alu_flags, go to CRC.
  - Counter reaches ALU_TIMEOUT without alu_done: err_flags=6'b001001, go to SEND with tx_err=1.
  - alu_done in the same cycle as timeout: alu_done wins.
  - alu_done arriving in any other state is ignored.
- CRC: polynomial x^3+x+1, initial value 3'b000.
  - Message is the 37 bits {C[31:0], 1'b0, flags[3:0]}, processed MSB first, one bit per cycle.
  - Per bit: fb = crc[2]^bit; crc <= {crc[1], crc[0]^fb, fb}.
  - 6-bit bit counter; after 37 bits go to SEND.
  - Latency from alu_done to tx_valid is 38 cycles.
- SEND: tx_valid=1.
  - Data response: tx_c=C, tx_ctl={1'b0, flags, crc}.
  - Error response: tx_c=0, tx_ctl={1'b1, err_flags, p}, where p is even parity over {1'b1, err_flags} (so the byte has an even number of ones).
  - tx_* held stable while tx_valid&!tx_ready.
  - On tx_valid&tx_ready: tx_valid=0, in_ready=1 next cycle, return to IDLE.
- Error path latency: tx_valid is asserted the cycle after accept.
- in_valid while in_ready=0: ignored; the upstream block holds the request.
- Reset mid-operation (any state): immediate return to reset values; partial CRC and captured data discarded; no response is emitted.

Optional Feature:
Macro MTM_ALU_CTRL_STATS_EN.
- Defined: adds output ports stat_ok [15:0] and stat_err [15:0], reset to 0.
  - stat_ok increments on each accepted data response handshake.
  - stat_err increments on each accepted error response handshake.
  - Both saturate at 16'hFFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- ADD A=0, B=0; ALU returns C=0, flags=4'b0010 after 3 cycles -> one alu_start pulse, alu_op=100; tx_valid 38 cycles after alu_done; tx_err=0, tx_c=0, tx_ctl=8'h16.
- in_err=6'b100100 -> no alu_start; tx_valid next cycle; tx_err=1, tx_ctl=8'hC9, tx_c=0.
- in_op=3'b011, in_err=0 -> no alu_start; tx_ctl=8'h93.
- Legal op, alu_done never asserted -> tx_ctl=8'h93 issued ALU_TIMEOUT(15) cycles after alu_start; a late alu_done afterwards is ignored.
- Data response with tx_ready held low 10 cycles -> tx_valid and tx_* stable for all 10 cycles; in_valid during that window not accepted; in_ready=1 the cycle after the handshake.
- rst pulsed during CRC state -> all outputs at reset values; next request processed normally; with MTM_ALU_CTRL_STATS_EN, stat_ok/stat_err=0 after reset and stat_ok=1 after the next data handshake.
